mem_dispatcher__write_rr: RTL and testbench
===========================================

# mem_dispatcher__write_rr

Multi-channel successor to the single-stream DDR write dispatcher. It moves fixed-size frames from up to NUM_CH local block-RAM buffers into external memory through one MCB-style write port. Requests are arbitrated round-robin, and each frame is split into bursts of BURST_LEN words, with a shorter tail burst when needed. It sits between the per-stream line buffers and the memory controller port and replaces hand-instantiated single-channel writers.

## Interface
- NUM_CH, 2: number of source channels (1..8)
- FRAME_WORDS, 640: words per job (1..2^17-1)
- BURST_LEN, 32: words per command (1..64)
- RAM_ADDR_BITS, 10: local buffer address width; FRAME_WORDS ≤ 2^RAM_ADDR_BITS
- DDR_PORT_BITS, 32: port data width; BYTES = DDR_PORT_BITS/8
- clk  in  1  single clock for all logic
- rst_n  in  1  reset, asynchronous, active-low
- ch_start  in  NUM_CH  per-channel one-cycle job request
- ch_base_addr  in  30*NUM_CH  per-channel byte base address; channel k occupies bits [30k+29:30k]
- ch_done  out  NUM_CH  one-cycle pulse when channel's last command is accepted
- busy_unit  out  1  high unless idle-and-calibrated
- ch_sel  out  clog2(NUM_CH) (min 1)  channel currently owning data_in
- data_in__addr  out  RAM_ADDR_BITS  local buffer read address
- data_in  in  DDR_PORT_BITS  read data, valid 1 cycle after address
- mem_calib_done  in  1  controller calibrated
- port_cmd_en / port_cmd_instr[2:0] / port_cmd_bl[5:0] / port_cmd_byte_addr[29:0]  out  command bus
- port_cmd_full  in  1  command FIFO full
- port_wr_en  out  1; port_wr_data_out  out  DDR_PORT_BITS
- port_wr_full  in  1  write FIFO full

## Operation
- Reset values: busy_unit=1, ch_done=0, ch_sel=0, data_in__addr=0, port_cmd_en=0, port_cmd_instr=0, port_cmd_bl=0, port_cmd_byte_addr=0, port_wr_en=0. The pending register, round-robin pointer and all counters are cleared to 0. State goes to CALIB.
- States:
  - CALIB: busy=1; moves to ARB when mem_calib_done=1.
  - ARB: if no request is pending, busy=0. Otherwise grant the first pending channel at or after the pointer, in cyclic order. On grant: clear its pending bit, set ch_sel, latch its base address, set pointer to (grant+1) mod NUM_CH, set data_in__addr=0, go to FILL.
  - FILL: issue reads and push words to the port until n words of this burst are written, then go to CMD. n = BURST_LEN, or for the tail burst FRAME_WORDS mod BURST_LEN when that is nonzero.
  - CMD: hold port_cmd_en=1 until a cycle with port_cmd_full=0; that cycle is the accept.
    - Command fields: instr=3'b000, bl=n-1, byte_addr=base+burst_idx*BURST_LEN*BYTES (30-bit wrap).
    - After accept: if the frame is complete, pulse ch_done[ch_sel] and go to ARB; else increment burst_idx and go to FILL.
- Request capture: ch_start[k] sets pending[k] in every state, including CALIB and while channel k itself is active. A start for an already-pending channel is absorbed. Simultaneous starts are all latched.
- Data path:
  - Reads go through a 2-entry skid buffer. port_wr_en=1 only when the buffer is non-empty and port_wr_full=0.
  - A new read is issued only if buffered plus in-flight entries are below 2 and the issued count is below n.
  - No word is lost, duplicated or reordered under any port_wr_full pattern.
- data_in__addr increments once per issued read and is continuous across bursts within a job, ending at FRAME_WORDS-1.
- mem_calib_done dropping mid-job is ignored; the job completes.

## Timing
- Grant is in cycle T. The first read address is valid in T+1, and the first port_wr_en is at T+2 at the earliest.
- With no backpressure, a burst of n words writes on n consecutive cycles. port_cmd_en asserts the cycle after the last write, so the command never precedes its data.
- A job of FRAME_WORDS=640, BURST_LEN=32 takes 20 bursts, minimum 20*(32+2) cycles from grant to ch_done.
- ch_done pulses in the cycle after command accept. busy_unit goes low in the following ARB cycle if nothing is pending.
- rst_n assertion mid-burst clears state immediately. Partial data already pushed to the port is abandoned, with no command issued.

## Test plan
- Single channel, calib at cycle 10, ch_start[0] with base 0x100, no backpressure -> 20 commands bl=31, addresses 0x100+128*i, 640 writes in order, one ch_done[0].
- FRAME_WORDS=100, BURST_LEN=32 -> commands bl=31,31,31,3; last address base+384; data_in__addr ends at 99.
- Random port_wr_full (50% duty) and port_cmd_full bursts -> port_wr_data sequence equals buffer contents 0..639 exactly; port_cmd_en held until accept.
- ch_start[0] and ch_start[1] in the same cycle, pointer=0 -> channel 0 serviced fully, then channel 1; a re-request of channel 0 during its own job -> serviced after channel 1.
- ch_start pulsed before mem_calib_done -> no port activity until calibration, then the job runs.
- rst_n low mid-FILL -> all outputs at reset values asynchronously, and no command is issued for the partial burst.

Source files
------------

// File: rtl/mem_dispatcher__write_rr.sv
`default_nettype none
// ============================================================================
// Module   : mem_dispatcher__write_rr
// Brief    : Round-robin multi-channel frame writer into one MCB-style write
//            port; frames are split into BURST_LEN-word commands plus a tail.
// Revision : 1.0  initial release
// ============================================================================
module mem_dispatcher__write_rr #(
    parameter int NUM_CH        = 2,
    parameter int FRAME_WORDS   = 640,
    parameter int BURST_LEN     = 32,
    parameter int RAM_ADDR_BITS = 10,
    parameter int DDR_PORT_BITS = 32
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [NUM_CH-1:0]                               ch_start,
    input  logic [30*NUM_CH-1:0]                            ch_base_addr,
    output logic [NUM_CH-1:0]                               ch_done,
    output logic                                            busy_unit,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  ch_sel,
    output logic [RAM_ADDR_BITS-1:0]                        data_in__addr,
    input  logic [DDR_PORT_BITS-1:0]                        data_in,
    input  logic                                            mem_calib_done,
    output logic                                            port_cmd_en,
    output logic [2:0]                                      port_cmd_instr,
    output logic [5:0]                                      port_cmd_bl,
    output logic [29:0]                                     port_cmd_byte_addr,
    input  logic                                            port_cmd_full,
    output logic                                            port_wr_en,
    output logic [DDR_PORT_BITS-1:0]                        port_wr_data_out,
    input  logic                                            port_wr_full
);

    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_jw        = CH_W + 1;
    localparam int c_bytes     = DDR_PORT_BITS / 8;
    localparam int c_bursts    = (FRAME_WORDS + BURST_LEN - 1) / BURST_LEN;
    localparam int c_tail      = FRAME_WORDS % BURST_LEN;
    localparam int BIDX_W      = (c_bursts > 1) ? $clog2(c_bursts) : 1;

    localparam logic [29:0]              c_stride     = 30'(BURST_LEN * c_bytes);
    localparam logic [6:0]               c_full_n     = 7'(BURST_LEN);
    localparam logic [6:0]               c_tail_n     = 7'(c_tail);
    localparam logic [BIDX_W-1:0]        c_last_burst = BIDX_W'(c_bursts - 1);
    localparam logic [RAM_ADDR_BITS-1:0] c_last_addr  = RAM_ADDR_BITS'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        S_CALIB = 2'd0,
        S_ARB   = 2'd1,
        S_FILL  = 2'd2,
        S_CMD   = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [NUM_CH-1:0]          r_pending;
    logic [CH_W-1:0]            r_rr_ptr;
    logic [29:0]                r_cmd_addr;
    logic [BIDX_W-1:0]          r_burst_idx;
    logic [6:0]                 r_issued;
    logic [6:0]                 r_written;
    logic                       r_in_flight;
    logic [1:0]                 r_sk_cnt;
    logic [DDR_PORT_BITS-1:0]   r_sk0;
    logic [DDR_PORT_BITS-1:0]   r_sk1;

    logic                       w_gnt_found;
    logic [CH_W-1:0]            w_gnt_idx;
    logic [29:0]                w_gnt_base;
    logic [c_jw-1:0]            w_j;
    logic                       w_grant;
    logic [NUM_CH-1:0]          w_gnt_onehot;
    logic [CH_W-1:0]            w_next_ptr;
    logic                       w_last_burst;
    logic [6:0]                 w_burst_n;
    logic                       w_pop;
    logic                       w_issue;
    logic                       w_accept;
    logic                       w_fill_done;

    // First pending channel at or after the pointer, searched cyclically.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_gnt_base  = '0;
        w_j         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_j = {1'b0, r_rr_ptr} + c_jw'(i);
            if (w_j >= c_jw'(NUM_CH)) begin
                w_j = w_j - c_jw'(NUM_CH);
            end
            if (!w_gnt_found && r_pending[w_j[CH_W-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_j[CH_W-1:0];
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt_idx == CH_W'(i)) begin
                w_gnt_base = ch_base_addr[30*i +: 30];
            end
        end
    end

    assign w_grant      = (r_state == S_ARB) && w_gnt_found;
    assign w_gnt_onehot = NUM_CH'(1) << w_gnt_idx;
    assign w_next_ptr   = (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;

    assign w_last_burst = (r_burst_idx == c_last_burst);
    assign w_burst_n    = (w_last_burst && (c_tail != 0)) ? c_tail_n : c_full_n;

    // Skid head is the oldest buffered word, else the word arriving this cycle.
    assign w_pop        = ((r_sk_cnt != 2'd0) || r_in_flight) && !port_wr_full;
    assign w_issue      = (r_state == S_FILL)
                        && (({1'b0, r_sk_cnt} + {2'b0, r_in_flight}) < 3'd2)
                        && (r_issued < w_burst_n);
    assign w_accept     = (r_state == S_CMD) && !port_cmd_full;
    assign w_fill_done  = w_pop && ((r_written + 7'd1) == w_burst_n);

    assign port_wr_en       = w_pop;
    assign port_wr_data_out = (r_sk_cnt != 2'd0) ? r_sk0 : data_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CALIB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        busy_unit          = 1'b1;
        port_cmd_en        = 1'b0;
        port_cmd_instr     = 3'b000;
        port_cmd_bl        = 6'd0;
        port_cmd_byte_addr = 30'd0;
        case (r_state)
            S_CALIB: begin
                if (mem_calib_done) begin
                    w_state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                if (r_pending == '0) begin
                    busy_unit = 1'b0;
                end
                if (w_gnt_found) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (w_fill_done) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                port_cmd_en        = 1'b1;
                port_cmd_bl        = 6'(w_burst_n - 7'd1);
                port_cmd_byte_addr = r_cmd_addr;
                if (w_accept) begin
                    w_state_nxt = w_last_burst ? S_ARB : S_FILL;
                end
            end
            default: w_state_nxt = S_CALIB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending     <= '0;
            r_rr_ptr      <= '0;
            ch_sel        <= '0;
            ch_done       <= '0;
            r_cmd_addr    <= '0;
            r_burst_idx   <= '0;
            r_issued      <= '0;
            r_written     <= '0;
            data_in__addr <= '0;
            r_in_flight   <= 1'b0;
            r_sk_cnt      <= 2'd0;
            r_sk0         <= '0;
            r_sk1         <= '0;
        end else begin
            // A start arriving with the grant of the same channel re-arms it.
            r_pending <= (r_pending & ~(w_grant ? w_gnt_onehot : '0)) | ch_start;
            ch_done   <= '0;

            if (w_grant) begin
                ch_sel        <= w_gnt_idx;
                r_rr_ptr      <= w_next_ptr;
                r_cmd_addr    <= w_gnt_base;
                r_burst_idx   <= '0;
                r_issued      <= '0;
                r_written     <= '0;
                data_in__addr <= '0;
            end

            if (w_issue) begin
                r_issued <= r_issued + 7'd1;
                if (data_in__addr != c_last_addr) begin
                    data_in__addr <= data_in__addr + 1'b1;
                end
            end
            if (w_pop) begin
                r_written <= r_written + 7'd1;
            end

            r_in_flight <= w_issue;
            if (w_pop && (r_sk_cnt == 2'd2)) begin
                r_sk0 <= r_sk1;
            end
            if (r_in_flight) begin
                if ((r_sk_cnt == 2'd0) && !w_pop) begin
                    r_sk0 <= data_in;
                end else if (r_sk_cnt == 2'd1) begin
                    if (w_pop) begin
                        r_sk0 <= data_in;
                    end else begin
                        r_sk1 <= data_in;
                    end
                end
            end
            r_sk_cnt <= r_sk_cnt + {1'b0, r_in_flight} - {1'b0, w_pop};

            if (w_accept) begin
                r_issued  <= '0;
                r_written <= '0;
                if (w_last_burst) begin
                    ch_done <= NUM_CH'(1) << ch_sel;
                end else begin
                    r_burst_idx <= r_burst_idx + 1'b1;
                    r_cmd_addr  <= r_cmd_addr + c_stride;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_dispatcher__write_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_dispatcher__write_rr
// Brief    : Directed self-checking bench, 2 channels, 100-word frames,
//            32-word bursts (tail of 4 words).
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_dispatcher__write_rr;

    localparam logic [29:0] c_base0 = 30'h0000_0100;
    localparam logic [29:0] c_base1 = 30'h3FFF_FF00;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ch_start;
    logic [59:0] ch_base_addr;
    logic [1:0]  ch_done;
    logic        busy_unit;
    logic [0:0]  ch_sel;
    logic [9:0]  data_in__addr;
    logic [31:0] data_in;
    logic        mem_calib_done;
    logic        port_cmd_en;
    logic [2:0]  port_cmd_instr;
    logic [5:0]  port_cmd_bl;
    logic [29:0] port_cmd_byte_addr;
    logic        port_cmd_full = 1'b0;
    logic        port_wr_en;
    logic [31:0] port_wr_data_out;
    logic        port_wr_full  = 1'b0;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        bp_en = 1'b0;

    logic [31:0] wq[$];
    logic [38:0] cq[$];
    int          cw[$];
    int          cg[$];
    int          dq[$];
    int          wr_since_cmd = 0;
    int          last_wr_cyc  = 0;
    int          hold_err     = 0;
    logic        hold_pend    = 1'b0;
    logic [29:0] hold_addr    = '0;

    mem_dispatcher__write_rr #(
        .NUM_CH        (2),
        .FRAME_WORDS   (100),
        .BURST_LEN     (32),
        .RAM_ADDR_BITS (10),
        .DDR_PORT_BITS (32)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ch_start           (ch_start),
        .ch_base_addr       (ch_base_addr),
        .ch_done            (ch_done),
        .busy_unit          (busy_unit),
        .ch_sel             (ch_sel),
        .data_in__addr      (data_in__addr),
        .data_in            (data_in),
        .mem_calib_done     (mem_calib_done),
        .port_cmd_en        (port_cmd_en),
        .port_cmd_instr     (port_cmd_instr),
        .port_cmd_bl        (port_cmd_bl),
        .port_cmd_byte_addr (port_cmd_byte_addr),
        .port_cmd_full      (port_cmd_full),
        .port_wr_en         (port_wr_en),
        .port_wr_data_out   (port_wr_data_out),
        .port_wr_full       (port_wr_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word(input int ch, input int a);
        logic [31:0] v;
        v        = 32'hD000_0000;
        v[23:16] = 8'(ch);
        v[15:0]  = 16'(a);
        return v;
    endfunction

    // Synchronous-read buffer model for whichever channel owns the port.
    always @(posedge clk) data_in <= word(int'(ch_sel), int'(data_in__addr));

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                port_wr_full  = ($urandom_range(0, 1) == 1);
                port_cmd_full = ($urandom_range(0, 3) != 0);
            end else begin
                port_wr_full  = 1'b0;
                port_cmd_full = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend    = 1'b0;
            wr_since_cmd = 0;
        end else begin
            if (hold_pend && (!port_cmd_en || (port_cmd_byte_addr != hold_addr))) begin
                hold_err++;
            end
            hold_pend = port_cmd_en && port_cmd_full;
            hold_addr = port_cmd_byte_addr;
            if (port_wr_en) begin
                wq.push_back(port_wr_data_out);
                last_wr_cyc = cyc;
                wr_since_cmd++;
            end
            if (port_cmd_en && !port_cmd_full) begin
                cq.push_back({port_cmd_instr, port_cmd_bl, port_cmd_byte_addr});
                cw.push_back(wr_since_cmd);
                cg.push_back(cyc - last_wr_cyc);
                wr_since_cmd = 0;
            end
            for (int k = 0; k < 2; k++) begin
                if (ch_done[k]) dq.push_back(k);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete(); cq.delete(); cw.delete(); cg.delete(); dq.delete();
    endtask

    task automatic pulse_start(input logic [1:0] m);
        ch_start = m;
        tick(1);
        ch_start = 2'b00;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while ((dq.size() < n) && (k < budget)) begin
            tick(1);
            k++;
        end
        check("done_count", 64'(dq.size()), 64'(n));
    endtask

    // Job j in the current queues: bursts of 32,32,32,4 words.
    task automatic verify_job(input int ch, input logic [29:0] base, input int j, input bit gapchk);
        int n;
        int idx;
        int bad;
        logic [29:0] ea;
        for (int b = 0; b < 4; b++) begin
            n   = (b == 3) ? 4 : 32;
            idx = 4 * j + b;
            ea  = 30'(base + 30'(b * 128));
            check("cmd_instr", 64'(cq[idx][38:36]), 64'(0));
            check("cmd_bl",    64'(cq[idx][35:30]), 64'(n - 1));
            check("cmd_addr",  64'(cq[idx][29:0]),  64'(ea));
            check("cmd_words", 64'(cw[idx]),        64'(n));
            if (gapchk) check("cmd_gap", 64'(cg[idx]), 64'(1));
        end
        bad = -1;
        for (int w = 0; w < 100; w++) begin
            if ((bad < 0) && (wq[100 * j + w] !== word(ch, w))) bad = w;
        end
        idx = (bad < 0) ? 99 : bad;
        check("wr_data", 64'(wq[100 * j + idx]), 64'(word(ch, idx)));
    endtask

    initial begin
        int k;
        rst_n          = 1'b0;
        mem_calib_done = 1'b0;
        ch_start       = 2'b00;
        ch_base_addr   = {c_base1, c_base0};
        tick(3);

        check("rst_busy",     64'(busy_unit),          64'(1));
        check("rst_done",     64'(ch_done),            64'(0));
        check("rst_ch_sel",   64'(ch_sel),             64'(0));
        check("rst_rd_addr",  64'(data_in__addr),      64'(0));
        check("rst_cmd_en",   64'(port_cmd_en),        64'(0));
        check("rst_cmd_bl",   64'(port_cmd_bl),        64'(0));
        check("rst_cmd_addr", 64'(port_cmd_byte_addr), 64'(0));
        check("rst_wr_en",    64'(port_wr_en),         64'(0));

        // Request before calibration: nothing moves until calib arrives.
        rst_n = 1'b1;
        pulse_start(2'b01);
        tick(8);
        check("precal_writes", 64'(wq.size()), 64'(0));
        check("precal_cmds",   64'(cq.size()), 64'(0));
        check("precal_busy",   64'(busy_unit), 64'(1));
        mem_calib_done = 1'b1;
        wait_done(1, 400);
        check("job0_rd_addr", 64'(data_in__addr), 64'(99));
        check("job0_writes",  64'(wq.size()),     64'(100));
        check("job0_cmds",    64'(cq.size()),     64'(4));
        check("job0_done_ch", 64'(dq[0]),         64'(0));
        verify_job(0, c_base0, 0, 1'b1);
        tick(2);
        check("idle_busy", 64'(busy_unit), 64'(0));
        check("one_done",  64'(dq.size()), 64'(1));

        // Channel 1 under random backpressure; address wraps at 30 bits.
        clear_mon();
        bp_en = 1'b1;
        pulse_start(2'b10);
        wait_done(1, 3000);
        bp_en = 1'b0;
        check("bp_ch_sel",   64'(ch_sel),     64'(1));
        check("bp_writes",   64'(wq.size()),  64'(100));
        check("bp_hold_err", 64'(hold_err),   64'(0));
        check("bp_done_ch",  64'(dq[0]),      64'(1));
        verify_job(1, c_base1, 0, 1'b0);
        tick(3);

        // Simultaneous starts, then channel 0 re-requests during its own job.
        clear_mon();
        pulse_start(2'b11);
        k = 0;
        while ((wq.size() < 10) && (k < 200)) begin
            tick(1);
            k++;
        end
        check("rr_mid_job", 64'(wq.size() >= 10), 64'(1));
        pulse_start(2'b01);
        wait_done(3, 2000);
        check("rr_order0", 64'(dq[0]), 64'(0));
        check("rr_order1", 64'(dq[1]), 64'(1));
        check("rr_order2", 64'(dq[2]), 64'(0));
        check("rr_writes", 64'(wq.size()), 64'(300));
        verify_job(0, c_base0, 0, 1'b1);
        verify_job(1, c_base1, 1, 1'b1);
        verify_job(0, c_base0, 2, 1'b1);
        tick(3);

        // Asynchronous reset in the middle of the second burst.
        clear_mon();
        pulse_start(2'b01);
        k = 0;
        while (((cq.size() < 1) || (wq.size() < 40)) && (k < 300)) begin
            tick(1);
            k++;
        end
        check("rstmid_reached", 64'(wq.size() >= 40), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",     64'(busy_unit),          64'(1));
        check("arst_wr_en",    64'(port_wr_en),         64'(0));
        check("arst_cmd_en",   64'(port_cmd_en),        64'(0));
        check("arst_rd_addr",  64'(data_in__addr),      64'(0));
        check("arst_cmd_addr", 64'(port_cmd_byte_addr), 64'(0));
        check("arst_done",     64'(ch_done),            64'(0));
        tick(3);
        rst_n = 1'b1;
        tick(20);
        check("arst_cmds",      64'(cq.size()), 64'(1));
        check("arst_no_done",   64'(dq.size()), 64'(0));
        check("arst_idle_busy", 64'(busy_unit), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
